stream_packet_source: RTL

- Single-clock packet generator that drives the sorter's sink-side streaming protocol: valid/ready handshake with sop/eop framing.
- On a start request it emits one packet of pseudo-random words from an LFSR, with programmable length, honouring backpressure.
- Sits in front of the sorter in on-chip self-test and bring-up builds. It replaces bench-driven stimulus on hardware.

---
 rtl/stream_packet_source_if.sv | 26 ++
 rtl/stream_packet_source.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/stream_packet_source_if.sv
// Streaming source-side bundle: valid/ready handshake with sop/eop framing.
interface stream_packet_source_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  src_valid;
    logic                  src_ready;
    logic                  src_sop;
    logic                  src_eop;
    logic [DATA_WIDTH-1:0] src_data;

    modport master (
        output src_valid,
        output src_sop,
        output src_eop,
        output src_data,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_sop,
        input  src_eop,
        input  src_data,
        output src_ready
    );
endinterface

// File: rtl/stream_packet_source.sv
// Self-test packet generator: emits one packet of LFSR words per start request,
// honouring backpressure, with registered outputs and a one-cycle done pulse.
module stream_packet_source #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    MAX_LENGTH = 30,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 16'hB400,
    parameter int unsigned           SEED       = 1
) (
    input  logic                               src_clock,
    input  logic                               src_reset,
    input  logic                               start,
    input  logic [$clog2(MAX_LENGTH+1)-1:0]    length,
    stream_packet_source_if.master             src,
    output logic                               busy,
    output logic                               done,
    output logic [15:0]                        pkt_count
);

    localparam int LW = $clog2(MAX_LENGTH + 1);
    localparam logic [LW-1:0]         MAX_LEN_W = LW'(MAX_LENGTH);
    localparam logic [DATA_WIDTH-1:0] SEED_W    = DATA_WIDTH'(SEED);
    localparam logic [DATA_WIDTH-1:0] SEED_EFF  =
        (SEED_W == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : SEED_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] s);
        lfsr_step = (s >> 1) ^ (s[0] ? LFSR_TAPS : {DATA_WIDTH{1'b0}});
    endfunction

    function automatic logic [DATA_WIDTH-1:0] word_of(input logic [DATA_WIDTH-1:0] s);
        word_of = {1'b0, s[DATA_WIDTH-2:0]};
    endfunction

    state_t                state_r;
    logic                  run_r;
    logic [LW-1:0]         beat_r;
    logic [LW-1:0]         len_r;
    logic [DATA_WIDTH-1:0] lfsr_r;
    logic                  valid_r;
    logic                  sop_r;
    logic                  eop_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  busy_r;
    logic                  done_r;
    logic [15:0]           pkt_count_r;

    logic [LW-1:0]         len_clamped_s;
    logic [LW-1:0]         beat_inc_s;
    logic                  eop_next_s;
    logic [DATA_WIDTH-1:0] lfsr_next_s;
    logic                  xfer_s;

    // Release synchroniser: start is honoured from the second edge after reset drops.
    always_ff @(posedge src_clock or posedge src_reset) begin
        if (src_reset) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Next-state helpers: length clamp, beat increment, LFSR advance.
    always_comb begin
        len_clamped_s = length;
        if (length > MAX_LEN_W) begin
            len_clamped_s = MAX_LEN_W;
        end else begin
            len_clamped_s = length;
        end
        beat_inc_s  = beat_r + LW'(1);
        eop_next_s  = (beat_inc_s == (len_r - LW'(1)));
        lfsr_next_s = lfsr_step(lfsr_r);
        xfer_s      = valid_r && src.src_ready;
    end

    // Packet FSM; every output is a register so nothing is combinational from ready/start.
    always_ff @(posedge src_clock or posedge src_reset) begin
        if (src_reset) begin
            state_r     <= ST_IDLE;
            beat_r      <= '0;
            len_r       <= '0;
            lfsr_r      <= SEED_EFF;
            valid_r     <= 1'b0;
            sop_r       <= 1'b0;
            eop_r       <= 1'b0;
            data_r      <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pkt_count_r <= 16'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (run_r && start) begin
                        if (len_clamped_s != '0) begin
                            len_r   <= len_clamped_s;
                            beat_r  <= '0;
                            valid_r <= 1'b1;
                            sop_r   <= 1'b1;
                            eop_r   <= (len_clamped_s == LW'(1));
                            data_r  <= word_of(lfsr_r);
                            busy_r  <= 1'b1;
                            state_r <= ST_SEND;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        lfsr_r <= lfsr_next_s;
                        if (eop_r) begin
                            valid_r     <= 1'b0;
                            sop_r       <= 1'b0;
                            eop_r       <= 1'b0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            pkt_count_r <= pkt_count_r + 16'd1;
                            state_r     <= ST_DONE;
                        end else begin
                            beat_r <= beat_inc_s;
                            sop_r  <= 1'b0;
                            eop_r  <= eop_next_s;
                            data_r <= word_of(lfsr_next_s);
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    sop_r   <= 1'b0;
                    eop_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign src.src_valid = valid_r;
    assign src.src_sop   = sop_r;
    assign src.src_eop   = eop_r;
    assign src.src_data  = data_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pkt_count     = pkt_count_r;

endmodule
